// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if: request/status bundle between transaction control and tone_scheduler
//   req     : one-shot tone request pulses, one bit per channel (bit 2 highest priority)
//   pending : latched, not-yet-served requests
//   busy    : tone or trailing gap in progress
//   active  : channel currently playing or gapping
//   done    : one-cycle pulse on natural tone completion
//   sample  : signed 8-bit value to the sigma-delta DAC
//   hush    : DAC mute
interface tone_scheduler_if;
    logic [2:0] req;
    logic [2:0] pending;
    logic       busy;
    logic [1:0] active;
    logic       done;
    logic [7:0] sample;
    logic       hush;
    modport master (output req, input pending, busy, active, done, sample, hush);
    modport slave  (input req, output pending, busy, active, done, sample, hush);
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler: fixed-priority one-shot tone sequencer driving a square wave into the speaker DAC
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : tone_scheduler_if.slave (req in; pending/busy/active/done/sample/hush out)
//   Optional macro TONE_PREEMPT_EN: a higher-priority pending request aborts the tone being played.
module tone_scheduler #(
    parameter logic [15:0] SAMPLE_DIV = 16'd1024,
    parameter logic [7:0]  HALF0      = 8'd20,
    parameter logic [7:0]  HALF1      = 8'd10,
    parameter logic [7:0]  HALF2      = 8'd40,
    parameter logic [15:0] DUR0       = 16'd400,
    parameter logic [15:0] DUR1       = 16'd2000,
    parameter logic [15:0] DUR2       = 16'd4000,
    parameter logic [15:0] GAP        = 16'd200,
    parameter logic [7:0]  AMP        = 8'd64
) (
    input logic             clk,
    input logic             reset_n,
    tone_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
    state_t      r_state;
    logic [15:0] r_div;
    logic [7:0]  r_half;
    logic [15:0] r_dur;
    logic [15:0] r_gap;
    logic        r_phase;
    logic [2:0]  r_pending;
    logic        r_busy;
    logic [1:0]  r_active;
    logic        r_done;
    logic [7:0]  r_sample;
    logic        r_hush;
    logic        w_tick;
    logic        w_preempt;
    logic        w_serve;
    logic [1:0]  w_sel;
    logic [7:0]  w_half_sel;
    logic [7:0]  w_half_act;
    logic [15:0] w_dur_sel;
    logic [2:0]  w_pend_next;
    logic [7:0]  w_amp_n;
    always_comb begin
        w_tick      = r_div == SAMPLE_DIV - 16'd1;
        w_sel       = r_pending[2] ? 2'd2 : r_pending[1] ? 2'd1 : 2'd0;
        w_half_sel  = w_sel == 2'd2 ? HALF2 : w_sel == 2'd1 ? HALF1 : HALF0;
        w_dur_sel   = w_sel == 2'd2 ? DUR2 : w_sel == 2'd1 ? DUR1 : DUR0;
        w_half_act  = r_active == 2'd2 ? HALF2 : r_active == 2'd1 ? HALF1 : HALF0;
        w_amp_n     = ~AMP + 8'd1;
`ifdef TONE_PREEMPT_EN
        // Any pending bit above the active index means a strictly higher priority request.
        w_preempt   = r_state == S_PLAY && (r_pending >> (r_active + 2'd1)) != 3'd0;
`else
        w_preempt   = 1'b0;
`endif
        w_serve     = (r_state == S_IDLE && r_pending != 3'd0) || w_preempt;
        // OR-ing req after the clear makes a same-cycle request win over the serve.
        w_pend_next = (r_pending & ~(w_serve ? 3'b001 << w_sel : 3'b000)) | bus.req;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_div     <= 16'd0;
            r_half    <= 8'd0;
            r_dur     <= 16'd0;
            r_gap     <= 16'd0;
            r_phase   <= 1'b1;
            r_pending <= 3'd0;
            r_busy    <= 1'b0;
            r_active  <= 2'd0;
            r_done    <= 1'b0;
            r_sample  <= 8'd0;
            r_hush    <= 1'b1;
        end else begin
            r_div     <= w_tick ? 16'd0 : r_div + 16'd1;
            r_pending <= w_pend_next;
            r_done    <= 1'b0;
            if (w_serve) begin
                r_state  <= S_PLAY;
                r_active <= w_sel;
                r_half   <= w_half_sel;
                r_dur    <= w_dur_sel;
                r_phase  <= 1'b1;
                r_sample <= AMP;
                r_hush   <= 1'b0;
                r_busy   <= 1'b1;
            end else if (r_state == S_PLAY && w_tick) begin
                if (r_dur == 16'd1) begin
                    r_state  <= S_GAP;
                    r_done   <= 1'b1;
                    r_sample <= 8'd0;
                    r_hush   <= 1'b1;
                    r_gap    <= GAP;
                end else begin
                    r_dur    <= r_dur - 16'd1;
                    r_half   <= r_half == 8'd1 ? w_half_act : r_half - 8'd1;
                    r_phase  <= r_half == 8'd1 ? ~r_phase : r_phase;
                    r_sample <= r_half == 8'd1 ? (r_phase ? w_amp_n : AMP) : r_sample;
                end
            end else if (r_state == S_GAP && w_tick) begin
                r_gap   <= r_gap - 16'd1;
                r_state <= r_gap == 16'd1 ? S_IDLE : S_GAP;
                r_busy  <= r_gap != 16'd1;
            end
        end
    end
    assign bus.pending = r_pending;
    assign bus.busy    = r_busy;
    assign bus.active  = r_active;
    assign bus.done    = r_done;
    assign bus.sample  = r_sample;
    assign bus.hush    = r_hush;
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: randomized and directed stimulus against a tick-count reference model of tone_scheduler
module tb_tone_scheduler;
    localparam logic [15:0] DIV = 16'd4;
    localparam logic [7:0]  H0  = 8'd3;
    localparam logic [7:0]  H1  = 8'd2;
    localparam logic [7:0]  H2  = 8'd1;
    localparam logic [15:0] D0  = 16'd10;
    localparam logic [15:0] D1  = 16'd8;
    localparam logic [15:0] D2  = 16'd5;
    localparam logic [15:0] GP  = 16'd3;
    localparam logic [7:0]  AM  = 8'd64;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tone_scheduler_if bus ();
    tone_scheduler #(
        .SAMPLE_DIV(DIV), .HALF0(H0), .HALF1(H1), .HALF2(H2),
        .DUR0(D0), .DUR1(D1), .DUR2(D2), .GAP(GP), .AMP(AM)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: cycles since reset, whether a tone (incl. gap) is in progress,
    // its channel and the number of sample ticks elapsed since it started.
    int         n;
    bit         m_busy;
    int         m_ch;
    int         m_k;
    logic [2:0] m_pend;
    bit         m_done;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int half_of(input int c);
        return c == 2 ? int'(H2) : c == 1 ? int'(H1) : int'(H0);
    endfunction

    function automatic int dur_of(input int c);
        return c == 2 ? int'(D2) : c == 1 ? int'(D1) : int'(D0);
    endfunction

    task automatic model_reset();
        n = 0;
        m_busy = 0;
        m_ch = 0;
        m_k = 0;
        m_pend = 3'd0;
        m_done = 0;
    endtask

    task automatic compare();
        bit playing;
        logic [7:0] s;
        playing = m_busy && m_k < dur_of(m_ch);
        s = !playing ? 8'd0 : ((m_k / half_of(m_ch)) % 2 == 0) ? AM : 8'(256 - int'(AM));
        check("busy", 16'(bus.busy), 16'(m_busy));
        check("active", 16'(bus.active), 16'(m_ch));
        check("done", 16'(bus.done), 16'(m_done));
        check("sample", 16'(bus.sample), 16'(s));
        check("hush", 16'(bus.hush), 16'(!playing));
        check("pending", 16'(bus.pending), 16'(m_pend));
    endtask

    task automatic step(input logic [2:0] r);
        bit tick;
        int sel;
        bus.req = r;
        @(posedge clk);
        #1;
        tick = (n % int'(DIV)) == int'(DIV) - 1;
        n++;
        m_done = 0;
        sel = m_pend[2] ? 2 : m_pend[1] ? 1 : 0;
        if (!m_busy) begin
            if (m_pend != 3'd0) begin
                m_busy = 1;
                m_ch = sel;
                m_k = 0;
                m_pend[sel] = 1'b0;
            end
        end
`ifdef TONE_PREEMPT_EN
        else if (m_k < dur_of(m_ch) && sel > m_ch) begin
            m_ch = sel;
            m_k = 0;
            m_pend[sel] = 1'b0;
        end
`endif
        else if (tick) begin
            m_k++;
            if (m_k == dur_of(m_ch)) m_done = 1;
            if (m_k == dur_of(m_ch) + int'(GP)) m_busy = 0;
        end
        m_pend |= r;
        compare();
        bus.req = 3'd0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(3'd0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_sample", 16'(bus.sample), 16'd0);
        check("rst_hush", 16'(bus.hush), 16'd1);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_pending", 16'(bus.pending), 16'd0);
        check("rst_active", 16'(bus.active), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req = 3'd0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        reset_n = 1'b1;
        idle(3);
        // single tone on channel 1
        step(3'b010);
        idle(80);
        // simultaneous requests: channel 2 first, then channel 0
        step(3'b101);
        idle(150);
        // same-channel re-request mid-tone replays after the gap
        step(3'b010);
        idle(10);
        step(3'b010);
        idle(120);
        // request landing on the serve edge of the same channel
        step(3'b100);
        step(3'b100);
        idle(100);
        // reset in the middle of a tone, then silence
        step(3'b001);
        idle(10);
        async_reset();
        idle(40);
        // higher-priority request during a channel 0 tone
        step(3'b001);
        idle(8);
        step(3'b100);
        idle(150);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 11) == 0 ? 3'($urandom_range(1, 7)) : 3'd0);
        async_reset();
        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7)) : 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
